frame_loader: RTL and testbench



---
 rtl/frame_loader.sv | 127 ++++++++++++
 tb/tb_frame_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// Assembles a stream of words into a NUM_WORDS-word frame and commits it with a fixed-length write strobe.
// Optional build macro FRAME_PARITY_EN adds per-beat even parity checking that suppresses the commit.
module frame_loader #(
  parameter int NUM_WORDS    = 16,
  parameter int WORD_W       = 32,
  parameter int WRITE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_sel,
  input  logic                        in_abort,
`ifdef FRAME_PARITY_EN
  input  logic                        in_parity,
  output logic                        parity_err,
`endif
  output logic [NUM_WORDS*WORD_W-1:0] frames_flat,
  output logic                        Small_or_Big,
  output logic                        write,
  output logic                        busy
);

  localparam int CNT_W = $clog2(NUM_WORDS);
  localparam int CMT_W = $clog2(WRITE_CYCLES + 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(NUM_WORDS - 1);
  localparam logic [CMT_W-1:0] CMT_LAST  = CMT_W'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t                               state, state_next;
  logic [CNT_W-1:0]                     word_cnt, word_cnt_next;
  logic [CMT_W-1:0]                     cmt_cnt, cmt_cnt_next;
  logic [NUM_WORDS-1:0][WORD_W-1:0]     frame;
  logic                                 beat;
  logic                                 write_next;

  // Abort wins over a simultaneous beat; no beats are taken while committing.
  assign in_ready    = rst_n && (state != COMMIT);
  assign beat        = in_valid && in_ready && !in_abort;
  assign frames_flat = frame;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_next    = state;
    word_cnt_next = word_cnt;
    cmt_cnt_next  = cmt_cnt;
    unique case (state)
      IDLE: begin
        if (beat) begin
          word_cnt_next = CNT_W'(1);
          state_next    = FILL;
        end
      end
      FILL: begin
        if (in_abort) begin
          word_cnt_next = '0;
          state_next    = IDLE;
        end else if (beat) begin
          if (word_cnt == WORD_LAST) begin
            word_cnt_next = '0;
            cmt_cnt_next  = '0;
            state_next    = COMMIT;
          end else begin
            word_cnt_next = word_cnt + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        if (cmt_cnt == CMT_LAST) begin
          cmt_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          cmt_cnt_next = cmt_cnt + CMT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FRAME_PARITY_EN
  logic err, err_next;

  // Sticky per-frame error; it covers the last beat too, since that beat decides the commit.
  always_comb begin
    err_next = err | (beat && (in_parity != ^in_data));
    if (state_next == IDLE) err_next = 1'b0;
    write_next = (state_next == COMMIT) && !err_next;
  end
`else
  assign write_next = (state_next == COMMIT);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all sequential state so every flop sees pre-edge values.
      state        <= IDLE;
      word_cnt     <= '0;
      cmt_cnt      <= '0;
      // NOTE: the frame storage is reset explicitly because downstream may observe it right after reset.
      frame        <= '0;
      Small_or_Big <= 1'b1;
      write        <= 1'b0;
      busy         <= 1'b0;
`ifdef FRAME_PARITY_EN
      err          <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      word_cnt <= word_cnt_next;
      cmt_cnt  <= cmt_cnt_next;
      if (beat) begin
        frame[word_cnt] <= in_data;
        if (state == IDLE) Small_or_Big <= in_sel;
      end
      write <= write_next;
      busy  <= (state_next != IDLE);
`ifdef FRAME_PARITY_EN
      err        <= err_next;
      parity_err <= (state != COMMIT) && (state_next == COMMIT) && err_next;
`endif
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader: a frame-level reference model predicts every output each cycle.
module tb_frame_loader;

  localparam int NW = 16;
  localparam int WW = 32;
  localparam int WC = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WW-1:0]    in_data;
  logic             in_sel;
  logic             in_abort;
  logic [NW*WW-1:0] frames_flat;
  logic             small_or_big;
  logic             write;
  logic             busy;
`ifdef FRAME_PARITY_EN
  logic             in_parity;
  logic             parity_err;
`endif

  frame_loader #(.NUM_WORDS(NW), .WORD_W(WW), .WRITE_CYCLES(WC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sel       (in_sel),
    .in_abort     (in_abort),
`ifdef FRAME_PARITY_EN
    .in_parity    (in_parity),
    .parity_err   (parity_err),
`endif
    .frames_flat  (frames_flat),
    .Small_or_Big (small_or_big),
    .write        (write),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_fail;

  // Reference model: words collected so far, the last frame contents and commit cycles remaining.
  logic [WW-1:0] m_frame [NW];
  bit            m_sel;
  int            m_cnt;
  int            m_left;
  bit            m_err;
  bit            m_bad;
  bit            m_perr;

  task automatic check(input string tag, input logic [NW*WW-1:0] got, input logic [NW*WW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NW*WW-1:0] model_flat();
    logic [NW*WW-1:0] f;
    for (int k = 0; k < NW; k++) f[k*WW +: WW] = m_frame[k];
    return f;
  endfunction

  task automatic model_update(input bit v, input logic [WW-1:0] d, input bit s, input bit a,
                              input bit r, input bit bad);
    m_perr = 1'b0;
    if (!r) begin
      for (int k = 0; k < NW; k++) m_frame[k] = '0;
      m_sel  = 1'b1;
      m_cnt  = 0;
      m_left = 0;
      m_err  = 1'b0;
      m_bad  = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (a) begin
      m_cnt = 0;
      m_err = 1'b0;
    end else if (v) begin
      if (m_cnt == 0) m_sel = s;
      m_frame[m_cnt] = d;
      if (bad) m_err = 1'b1;
      m_cnt++;
      if (m_cnt == NW) begin
        m_cnt  = 0;
        m_left = WC;
        m_bad  = m_err;
        m_perr = m_err;
        m_err  = 1'b0;
      end
    end
  endtask

  // One clock: drive at the falling edge, check ready before the rising edge, check state after it.
  task automatic step(input bit v, input logic [WW-1:0] d, input bit s, input bit a,
                      input bit r, input bit bad);
    rst_n    = r;
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    in_abort = a;
`ifdef FRAME_PARITY_EN
    in_parity = (^d) ^ bad;
`endif
    #1;
    check("in_ready", NW*WW'(in_ready), NW*WW'(r && (m_left == 0)));
    @(posedge clk);
    model_update(v, d, s, a, r, bad);
    #1;
    check("write", NW*WW'(write), NW*WW'((m_left > 0) && !m_bad));
    check("busy", NW*WW'(busy), NW*WW'((m_left > 0) || (m_cnt > 0)));
    check("Small_or_Big", NW*WW'(small_or_big), NW*WW'(m_sel));
    check("frames_flat", frames_flat, model_flat());
`ifdef FRAME_PARITY_EN
    check("parity_err", NW*WW'(parity_err), NW*WW'(m_perr));
`endif
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Sends NW beats with valid held high, waiting out any commit still in progress.
  task automatic send_frame(input logic [WW-1:0] base, input bit sel0, input bit gaps, input int bad_beat);
    for (int k = 0; k < NW; k++) begin
      bit acc;
      do begin
        acc = (m_left == 0);
        step(1'b1, base + WW'(k), (k == 0) ? sel0 : !sel0, 1'b0, 1'b1, k == bad_beat);
      end while (!acc);
      if (gaps && (k == 4 || k == 11)) idle(3);
    end
  endtask

  initial begin
    logic [WW-1:0] d;
    bit            v, s, a, r, bad, hold;

    n_vec    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sel   = 1'b0;
    in_abort = 1'b0;
`ifdef FRAME_PARITY_EN
    in_parity = 1'b0;
`endif
    for (int k = 0; k < NW; k++) m_frame[k] = '0;
    m_sel = 1'b1; m_cnt = 0; m_left = 0; m_err = 0; m_bad = 0; m_perr = 0;
    @(negedge clk);

    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    send_frame(32'h1000_0000, 1'b0, 1'b0, -1);
    idle(WC + 1);
    send_frame(32'h2000_0000, 1'b1, 1'b1, -1);
    idle(WC + 1);

    for (int k = 0; k < 7; k++) step(1'b1, 32'h3000_0000 + WW'(k), 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h3000_0007, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(32'hAAAA_0000, 1'b0, 1'b0, -1);
    idle(WC + 1);

    send_frame(32'h4000_0000, 1'b0, 1'b0, -1);
    send_frame(32'h5000_0000, 1'b1, 1'b0, -1);
    idle(WC + 1);

    send_frame(32'h6000_0000, 1'b0, 1'b0, -1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(32'h7000_0000, 1'b0, 1'b0, -1);
    idle(WC + 1);

`ifdef FRAME_PARITY_EN
    send_frame(32'h8000_0000, 1'b0, 1'b0, 9);
    idle(WC + 1);
    send_frame(32'h9000_0000, 1'b0, 1'b0, -1);
    idle(WC + 1);
`endif

    v = 1'b0; d = '0; s = 1'b0; hold = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        v = ($urandom_range(9) < 7);
        d = $urandom;
        s = $urandom_range(1) == 1;
      end
      a = ($urandom_range(39) == 0);
      r = ($urandom_range(149) != 0);
`ifdef FRAME_PARITY_EN
      bad = ($urandom_range(31) == 0);
`else
      bad = 1'b0;
`endif
      hold = v && r && (m_left > 0);
      step(v, d, s, a, r, bad);
    end
    idle(WC + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
